// File: rtl/bus_arbiter_ws.sv
// Two-master round-robin arbiter with region-specific wait-state sequencing
// for the shared system bus (MEM/TC/UART/GPIO).
module bus_arbiter_ws #(
  parameter int unsigned WS_MEM  = 0,
  parameter int unsigned WS_TC   = 1,
  parameter int unsigned WS_UART = 3,
  parameter int unsigned WS_GPIO = 1,
  parameter int unsigned CNT_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic        m0_we,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic        m1_we,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m_rdata,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [31:0] bus_wdata,
  output logic        bus_stb,
  input  logic [31:0] bus_rdata,
  output logic        grant
);

  // state  | meaning
  // IDLE   | arbitrate, sample winner's request, decode address
  // ACCESS | bus_stb high, counting down wait states
  // ACK    | one-cycle ack (and err if unmapped) to the granted master
  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  localparam logic [CNT_W-1:0] WS_MEM_C  = CNT_W'(WS_MEM);
  localparam logic [CNT_W-1:0] WS_TC_C   = CNT_W'(WS_TC);
  localparam logic [CNT_W-1:0] WS_UART_C = CNT_W'(WS_UART);
  localparam logic [CNT_W-1:0] WS_GPIO_C = CNT_W'(WS_GPIO);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             grant_q, grant_d;
  logic [31:0]      addr_q, addr_d;
  logic             we_q, we_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic             win_m1;
  logic [31:0]      win_addr;
  logic             hit;
  logic [CNT_W-1:0] ws;

  // Both requesting: the master not served last wins; reset leaves last=M1.
  assign win_m1   = m1_req && (!m0_req || !last_q);
  assign win_addr = win_m1 ? m1_addr : m0_addr;

  always_comb begin
    hit = 1'b1;
    ws  = '0;
    if (win_addr[31:13] == 19'h0)            ws = WS_MEM_C;
    else if (win_addr[31:12] == 20'hFFFF0)   ws = WS_TC_C;
    else if (win_addr[31:12] == 20'hFFFF1)   ws = WS_UART_C;
    else if (win_addr[31:12] == 20'hFFFF2)   ws = WS_GPIO_C;
    else                                     hit = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          grant_d = win_m1;
          last_d  = win_m1;
          addr_d  = win_addr;
          we_d    = win_m1 ? m1_we : m0_we;
          wdata_d = win_m1 ? m1_wdata : m0_wdata;
          rdata_d = '0;
          if (hit) begin
            cnt_d   = ws;
            err_d   = 1'b0;
            state_d = ACCESS;
          end else begin
            err_d   = 1'b1;
            state_d = ACK;
          end
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          rdata_d = we_q ? 32'h0 : bus_rdata;
          state_d = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      grant_q <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Strobe and acks decode from the state register, so reset clears them at once.
  assign bus_stb   = (state_q == ACCESS);
  assign m0_ack    = (state_q == ACK) && !grant_q;
  assign m1_ack    = (state_q == ACK) &&  grant_q;
  assign m0_err    = m0_ack && err_q;
  assign m1_err    = m1_ack && err_q;
  assign m_rdata   = (state_q == ACK) ? rdata_q : 32'h0;
  assign bus_addr  = addr_q;
  assign bus_we    = we_q;
  assign bus_wdata = wdata_q;
  assign grant     = grant_q;

endmodule
